// File: rtl/spd_mul_256_itr.sv
// Iterative 256x256 unsigned multiplier: one LIMB_W x LIMB_W partial product per cycle,
// accumulated into a 512-bit sum; the registered product holds until the next completion.
module spd_mul_256_itr #(
  parameter int unsigned LIMB_W   = 64,
  parameter int unsigned NUM_LIMB = 256 / LIMB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mul_vld_i,
  input  logic [255:0] op_a_i,
  input  logic [255:0] op_b_i,
  output logic         mul_rdy_o,
  output logic         mul_fin_o,
  output logic [511:0] p512_o
);

  localparam int unsigned LogN  = $clog2(NUM_LIMB);
  localparam int unsigned CntW  = 2 * LogN;
  localparam int unsigned NumPp = NUM_LIMB * NUM_LIMB;

  if (!(LIMB_W == 32 || LIMB_W == 64 || LIMB_W == 128) || (NUM_LIMB != 256 / LIMB_W))
  begin : g_param_chk
    $error("spd_mul_256_itr: LIMB_W must be 32, 64 or 128 and NUM_LIMB must be 256/LIMB_W");
  end

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [511:0]        acc_q, acc_d;
  logic [255:0]        a_q, a_d;
  logic [255:0]        b_q, b_d;
  logic [511:0]        p512_q, p512_d;
  logic                fin_q, fin_d;

  logic [LogN-1:0]     i_idx, j_idx;
  logic [LogN:0]       ij_sum;
  logic [9:0]          shamt;
  logic [LIMB_W-1:0]   a_limb, b_limb;
  logic [2*LIMB_W-1:0] pp;
  logic [511:0]        pp_sh;
  logic [511:0]        acc_sum;
  logic                last_mac;

  // cnt = i*NUM_LIMB + j, NUM_LIMB is a power of two so i/j are plain bit fields.
  assign i_idx    = cnt_q[CntW-1:LogN];
  assign j_idx    = cnt_q[LogN-1:0];
  assign ij_sum   = {1'b0, i_idx} + {1'b0, j_idx};
  assign shamt    = 10'(ij_sum) * 10'(LIMB_W);
  assign a_limb   = a_q[j_idx*LIMB_W +: LIMB_W];
  assign b_limb   = b_q[i_idx*LIMB_W +: LIMB_W];
  assign pp       = {{LIMB_W{1'b0}}, a_limb} * {{LIMB_W{1'b0}}, b_limb};
  assign pp_sh    = {{(512 - 2 * LIMB_W){1'b0}}, pp} << shamt;
  assign acc_sum  = acc_q + pp_sh;
  assign last_mac = (cnt_q == CntW'(NumPp - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    p512_d  = p512_q;
    fin_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mul_vld_i) begin
          a_d     = op_a_i;
          b_d     = op_b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last_mac) begin
          p512_d  = acc_sum;
          fin_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p512_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p512_q  <= p512_d;
      fin_q   <= fin_d;
    end
  end

  assign mul_rdy_o = (state_q == StIdle);
  assign mul_fin_o = fin_q;
  assign p512_o    = p512_q;

endmodule

// File: tb/tb_spd_mul_256_itr.sv
// Bench for spd_mul_256_itr: directed and random products checked against plain
// 512-bit multiplication, on LIMB_W = 64, 32 and 128 instances.
module tb_spd_mul_256_itr;

  localparam logic [255:0] P256 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] MAXV = '1;
  localparam int NB = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld  [3];
  logic [255:0] opa  [3];
  logic [255:0] opb  [3];
  logic         rdy  [3];
  logic         fin  [3];
  logic [511:0] prod [3];
  int           lat  [3] = '{16, 64, 4};

  int           tests = 0;
  int           fails = 0;
  logic [511:0] last_exp;

  always #5 clk = ~clk;

  spd_mul_256_itr #(.LIMB_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .mul_vld_i(vld[0]), .op_a_i(opa[0]), .op_b_i(opb[0]),
    .mul_rdy_o(rdy[0]), .mul_fin_o(fin[0]), .p512_o(prod[0])
  );
  spd_mul_256_itr #(.LIMB_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .mul_vld_i(vld[1]), .op_a_i(opa[1]), .op_b_i(opb[1]),
    .mul_rdy_o(rdy[1]), .mul_fin_o(fin[1]), .p512_o(prod[1])
  );
  spd_mul_256_itr #(.LIMB_W(128)) u_dut128 (
    .clk(clk), .rst(rst), .mul_vld_i(vld[2]), .op_a_i(opa[2]), .op_b_i(opb[2]),
    .mul_rdy_o(rdy[2]), .mul_fin_o(fin[2]), .p512_o(prod[2])
  );

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b);
    return {256'b0, a} * {256'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; it is accepted at the following rising edge.
  task automatic go(input int d, input logic [255:0] a, input logic [255:0] b);
    chk($sformatf("rdy_idle%0d", d), 512'(rdy[d]), 512'd1);
    vld[d] = 1'b1;
    opa[d] = a;
    opb[d] = b;
    @(negedge clk);
    vld[d] = 1'b0;
    opa[d] = rnd256();
    opb[d] = rnd256();
  endtask

  task automatic wait_fin(input int d, output int n);
    n = 0;
    while (fin[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input int d, input string tag, input logic [255:0] a,
                        input logic [255:0] b);
    int n;
    go(d, a, b);
    wait_fin(d, n);
    chk({tag, "_lat"}, 512'(n), 512'(lat[d]));
    chk({tag, "_prod"}, prod[d], model(a, b));
    last_exp = model(a, b);
    @(negedge clk);
    chk({tag, "_pulse"}, 512'(fin[d]), 512'd0);
    chk({tag, "_hold"}, prod[d], last_exp);
  endtask

  initial begin
    logic [255:0] a, b;
    logic [511:0] cur;
    int           n, sp;
    logic         ok, saw;

    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      opa[d] = rnd256();
      opb[d] = rnd256();
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_prod%0d", d), prod[d], 512'd0);
      chk($sformatf("rst_fin%0d", d), 512'(fin[d]), 512'd0);
      chk($sformatf("rst_rdy%0d", d), 512'(rdy[d]), 512'd1);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(0, "zero", 256'd0, P256);
    run_op(0, "max", MAXV, MAXV);
    chk("max_const", prod[0], {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1});
    run_op(0, "sm2", P256 - 256'd1, P256 - 256'd1);
    chk("sm2_mod", prod[0] % {256'b0, P256}, 512'd1);

    // Requests held during MAC must be ignored.
    a = rnd256();
    b = rnd256();
    go(0, a, b);
    ok = 1'b1;
    n  = 0;
    while (fin[0] !== 1'b1 && n < 200) begin
      if (rdy[0] !== 1'b0) ok = 1'b0;
      vld[0] = 1'b1;
      opa[0] = rnd256();
      opb[0] = rnd256();
      @(negedge clk);
      n++;
    end
    vld[0] = 1'b0;
    chk("busy_rdy_low", 512'(ok), 512'd1);
    chk("busy_lat", 512'(n), 512'd16);
    chk("busy_prod", prod[0], model(a, b));
    @(negedge clk);

    // Reset at MAC cycle 7 aborts the op with no completion.
    go(0, rnd256(), rnd256());
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_prod", prod[0], 512'd0);
    chk("abort_fin", 512'(fin[0]), 512'd0);
    chk("abort_rdy", 512'(rdy[0]), 512'd1);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (fin[0] === 1'b1) saw = 1'b1;
    end
    chk("abort_no_fin", 512'(saw), 512'd0);
    chk("abort_prod_late", prod[0], 512'd0);
    run_op(0, "post_rst", rnd256(), rnd256());

    // Back-to-back: new request in every fin cycle.
    a = rnd256();
    b = rnd256();
    go(0, a, b);
    cur = model(a, b);
    sp  = 1;
    ok  = 1'b1;
    for (int k = 0; k < NB; k++) begin
      while (fin[0] !== 1'b1 && sp < 100) begin
        if (prod[0] !== last_exp) ok = 1'b0;
        @(negedge clk);
        sp++;
      end
      chk($sformatf("b2b_prod%0d", k), prod[0], cur);
      chk($sformatf("b2b_space%0d", k), 512'(sp), 512'd17);
      chk($sformatf("b2b_stable%0d", k), 512'(ok), 512'd1);
      last_exp = cur;
      if (k < NB - 1) begin
        a = rnd256();
        b = rnd256();
        go(0, a, b);
        cur = model(a, b);
        sp  = 1;
        ok  = 1'b1;
      end
    end
    @(negedge clk);
    chk("b2b_last_pulse", 512'(fin[0]), 512'd0);

    // Other limb widths.
    for (int d = 1; d < 3; d++) begin
      run_op(d, $sformatf("w%0d_max", d), MAXV, MAXV);
      for (int r = 0; r < 3; r++) run_op(d, $sformatf("w%0d_rnd%0d", d, r), rnd256(), rnd256());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
